trace_checker: RTL and testbench

Golden-trace comparator for the writeback debug port of the pipelined CPU core: it consumes `debug_wb_pc`, `debug_wb_rf_we`, `debug_wb_rf_wnum` and `debug_wb_rf_wdata` and checks each register-file write against a preloaded reference trace. It latches the first mismatch and declares pass, fail or timeout. It sits beside the CPU in the SoC-level test harness and is the reading end of the trace debug interface.

---
 rtl/trace_checker.sv | 192 +++++++++++++++++++
 tb/tb_trace_checker.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// trace_checker: golden-trace comparator for the CPU writeback debug port.
//
// Every register-file write the core retires (except writes to r0) is
// compared against a preloaded reference trace. The first mismatch is latched
// and the block settles in PASS, FAIL or TOUT until reset.
//
// Parameters:
//   AW      - trace memory address width (depth 2^AW entries)
//   END_PC  - PC whose writeback marks program end
//   TIMEOUT - maximum RUN cycles without a checked write
//
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   load_en/addr/data    - trace memory write port, honoured only in IDLE;
//                          entry layout {pc[68:37], wnum[36:32], wdata[31:0]}
//   trace_len            - number of valid entries, sampled at start
//   start                - one-cycle pulse, IDLE -> RUN
//   debug_wb_*           - writeback debug port of the core under test
//   busy/done/pass/fail/timeout - status decoded from the state register
//   err_index/pc/wnum/wdata     - trace index and DUT values at first failure
//   retired_cnt          - checked writes since start (saturating)
module trace_checker #(
    parameter int unsigned AW      = 12,
    parameter logic [31:0] END_PC  = 32'h1c000100,
    parameter logic [15:0] TIMEOUT = 16'd10000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [68:0]   load_data,
    input  logic [AW:0]   trace_len,
    input  logic          start,
    input  logic [31:0]   debug_wb_pc,
    input  logic [3:0]    debug_wb_rf_we,
    input  logic [4:0]    debug_wb_rf_wnum,
    input  logic [31:0]   debug_wb_rf_wdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout,
    output logic [AW:0]   err_index,
    output logic [31:0]   err_pc,
    output logic [4:0]    err_wnum,
    output logic [31:0]   err_wdata,
    output logic [31:0]   retired_cnt
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTout} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic [AW:0]   len_q, len_d;
    logic [68:0]   exp_q, exp_d;
    logic [15:0]   wdog_q, wdog_d;
    logic [31:0]   ret_q, ret_d;
    logic [AW:0]   err_index_q, err_index_d;
    logic [31:0]   err_pc_q, err_pc_d;
    logic [4:0]    err_wnum_q, err_wnum_d;
    logic [31:0]   err_wdata_q, err_wdata_d;

    logic [68:0]   mem [Depth];

    logic          wr;
    logic          ev;
    logic          bad;
    logic          end_hit;
    logic [68:0]   obs;
    logic [AW:0]   ptr_inc;
    logic [AW-1:0] rd_addr;

    assign wr      = |debug_wb_rf_we;
    assign ev      = (state_q == StRun) && wr && (debug_wb_rf_wnum != 5'd0);
    assign end_hit = (state_q == StRun) && wr && (debug_wb_pc == END_PC);
    assign obs     = {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};
    assign ptr_inc = ptr_q + {{AW{1'b0}}, 1'b1};
    // A write beyond the trace length fails even if exp happens to match.
    assign bad     = ev && ((ptr_q == len_q) || (obs != exp_q));
    // Look one entry ahead on a check so a write every cycle sees fresh exp.
    assign rd_addr = ev ? ptr_inc[AW-1:0] : ptr_q[AW-1:0];

    // Trace memory has no reset: contents survive resetn for reruns.
    always_ff @(posedge clk) begin
        if ((state_q == StIdle) && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        exp_d       = exp_q;
        wdog_d      = wdog_q;
        ret_d       = ret_q;
        err_index_d = err_index_q;
        err_pc_d    = err_pc_q;
        err_wnum_d  = err_wnum_q;
        err_wdata_d = err_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    ptr_d   = '0;
                    len_d   = trace_len;
                    exp_d   = mem[{AW{1'b0}}];
                    wdog_d  = '0;
                    ret_d   = '0;
                end
            end
            StRun: begin
                exp_d = mem[rd_addr];
                if (bad) begin
                    state_d     = StFail;
                    err_index_d = ptr_q;
                    err_pc_d    = debug_wb_pc;
                    err_wnum_d  = debug_wb_rf_wnum;
                    err_wdata_d = debug_wb_rf_wdata;
                end else begin
                    if (ev) begin
                        ptr_d  = ptr_inc;
                        wdog_d = '0;
                        if (ret_q != 32'hffff_ffff) begin
                            ret_d = ret_q + 32'd1;
                        end
                    end else if (wdog_q != 16'hffff) begin
                        wdog_d = wdog_q + 16'd1;
                    end
                    // End detection judges the pointer after this cycle's check.
                    if (end_hit) begin
                        if (ptr_d == len_q) begin
                            state_d = StPass;
                        end else begin
                            state_d     = StFail;
                            err_index_d = ptr_d;
                            err_pc_d    = debug_wb_pc;
                            err_wnum_d  = debug_wb_rf_wnum;
                            err_wdata_d = debug_wb_rf_wdata;
                        end
                    end else if (wdog_q >= TIMEOUT) begin
                        state_d = StTout;
                    end
                end
            end
            default: begin
                // PASS, FAIL and TOUT hold until reset.
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            len_q       <= '0;
            exp_q       <= '0;
            wdog_q      <= '0;
            ret_q       <= '0;
            err_index_q <= '0;
            err_pc_q    <= '0;
            err_wnum_q  <= '0;
            err_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            exp_q       <= exp_d;
            wdog_q      <= wdog_d;
            ret_q       <= ret_d;
            err_index_q <= err_index_d;
            err_pc_q    <= err_pc_d;
            err_wnum_q  <= err_wnum_d;
            err_wdata_q <= err_wdata_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign pass        = (state_q == StPass);
    assign fail        = (state_q == StFail);
    assign timeout     = (state_q == StTout);
    assign done        = pass || fail || timeout;
    assign err_index   = err_index_q;
    assign err_pc      = err_pc_q;
    assign err_wnum    = err_wnum_q;
    assign err_wdata   = err_wdata_q;
    assign retired_cnt = ret_q;

endmodule

// File: tb/tb_trace_checker.sv
// Self-checking bench for trace_checker: directed vector table, a timeout
// sequence, and randomized traces checked against a behavioural model.
module tb_trace_checker;

    localparam int unsigned AW      = 4;
    localparam int unsigned LW      = AW + 1;
    localparam logic [31:0] END_PC  = 32'h1c000100;
    localparam logic [15:0] TOUT_CY = 16'd20;
    localparam logic [31:0] PC0     = 32'h1c000000;
    localparam logic [31:0] PC1     = 32'h1c000004;
    localparam logic [31:0] PC2     = 32'h1c000008;

    logic          clk;
    logic          resetn;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [68:0]   load_data;
    logic [AW:0]   trace_len;
    logic          start;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_we;
    logic [4:0]    debug_wb_rf_wnum;
    logic [31:0]   debug_wb_rf_wdata;
    logic          busy, done, pass, fail, timeout;
    logic [AW:0]   err_index;
    logic [31:0]   err_pc, err_wdata, retired_cnt;
    logic [4:0]    err_wnum;

    trace_checker #(
        .AW      (AW),
        .END_PC  (END_PC),
        .TIMEOUT (TOUT_CY)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .load_en           (load_en),
        .load_addr         (load_addr),
        .load_data         (load_data),
        .trace_len         (trace_len),
        .start             (start),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .fail              (fail),
        .timeout           (timeout),
        .err_index         (err_index),
        .err_pc            (err_pc),
        .err_wnum          (err_wnum),
        .err_wdata         (err_wdata),
        .retired_cnt       (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          st;
        logic [AW:0] len;
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        bit          busy;
        bit          pass;
        bit          fail;
        logic [31:0] ret;
        logic [AW:0] eidx;
        logic [31:0] epc;
        logic [31:0] ewdata;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit st, input logic [AW:0] len,
                                input logic [31:0] pc, input logic [3:0] we,
                                input logic [4:0] wnum, input logic [31:0] wdata,
                                input bit b, input bit p, input bit f,
                                input logic [31:0] ret, input logic [AW:0] eidx,
                                input logic [31:0] epc, input logic [31:0] ewdata);
        vec_t v;
        v.rst = rst; v.st = st; v.len = len; v.pc = pc; v.we = we; v.wnum = wnum;
        v.wdata = wdata; v.busy = b; v.pass = p; v.fail = f; v.ret = ret;
        v.eidx = eidx; v.epc = epc; v.ewdata = ewdata;
        return v;
    endfunction

    function automatic vec_t r_row();
        return mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t s_row(input logic [AW:0] len);
        return mk(0, 1, len, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    // Running write in RUN that matches, expecting ret checked writes so far.
    function automatic vec_t ok_row(input logic [31:0] pc, input logic [4:0] wnum,
                                    input logic [31:0] ret);
        return mk(0, 0, 3, pc, 4'hf, wnum, 32'(wnum), 1, 0, 0, ret, 0, 0, 0);
    endfunction

    vec_t tbl[$];

    task automatic check_row(input int i, input vec_t v);
        chk($sformatf("row%0d busy", i), 64'(busy), 64'(v.busy));
        chk($sformatf("row%0d pass", i), 64'(pass), 64'(v.pass));
        chk($sformatf("row%0d fail", i), 64'(fail), 64'(v.fail));
        chk($sformatf("row%0d timeout", i), 64'(timeout), 64'd0);
        chk($sformatf("row%0d done", i), 64'(done), 64'(v.pass | v.fail));
        chk($sformatf("row%0d retired_cnt", i), 64'(retired_cnt), 64'(v.ret));
        chk($sformatf("row%0d err_index", i), 64'(err_index), 64'(v.eidx));
        chk($sformatf("row%0d err_pc", i), 64'(err_pc), 64'(v.epc));
        chk($sformatf("row%0d err_wdata", i), 64'(err_wdata), 64'(v.ewdata));
    endtask

    task automatic idle_inputs();
        start = 0; load_en = 0; debug_wb_rf_we = 0; debug_wb_rf_wnum = 0;
        debug_wb_pc = 0; debug_wb_rf_wdata = 0;
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int MI = 0, MR = 1, MP = 2, MF = 3, MT = 4;
    int          m_ph;
    int          m_pos, m_len, m_quiet;
    logic [31:0] m_ret;
    logic [AW:0] m_eidx;
    logic [31:0] m_epc, m_ewdata;
    logic [4:0]  m_ewnum;
    logic [68:0] tmem [16];

    task automatic m_reset();
        m_ph = MI; m_pos = 0; m_len = 0; m_quiet = 0; m_ret = 0;
        m_eidx = 0; m_epc = 0; m_ewdata = 0; m_ewnum = 0;
    endtask

    task automatic m_fail(input int idx);
        m_ph = MF; m_eidx = LW'(idx); m_epc = debug_wb_pc;
        m_ewnum = debug_wb_rf_wnum; m_ewdata = debug_wb_rf_wdata;
    endtask

    // One clock edge of the reference, from the inputs present at that edge.
    task automatic m_step();
        logic [68:0] got;
        bit wr, cw;
        int quiet_before;
        got = {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};
        wr  = (debug_wb_rf_we != 0);
        cw  = wr && (debug_wb_rf_wnum != 0);
        if (m_ph == MI) begin
            if (load_en) tmem[load_addr] = load_data;
            if (start) begin
                m_ph = MR; m_pos = 0; m_len = int'(trace_len); m_quiet = 0; m_ret = 0;
            end
        end else if (m_ph == MR) begin
            if (cw && m_pos == m_len) m_fail(m_pos);
            else if (cw && got != tmem[m_pos]) m_fail(m_pos);
            else begin
                quiet_before = m_quiet;
                if (cw) begin
                    m_pos++;
                    m_quiet = 0;
                    if (m_ret != 32'hffff_ffff) m_ret++;
                end else if (m_quiet < 65535) m_quiet++;
                if (wr && debug_wb_pc == END_PC) begin
                    if (m_pos == m_len) m_ph = MP;
                    else m_fail(m_pos);
                end else if (quiet_before >= int'(TOUT_CY)) m_ph = MT;
            end
        end
    endtask

    task automatic m_check();
        chk("rnd busy", 64'(busy), 64'(m_ph == MR));
        chk("rnd pass", 64'(pass), 64'(m_ph == MP));
        chk("rnd fail", 64'(fail), 64'(m_ph == MF));
        chk("rnd timeout", 64'(timeout), 64'(m_ph == MT));
        chk("rnd done", 64'(done), 64'(m_ph >= MP));
        chk("rnd retired_cnt", 64'(retired_cnt), 64'(m_ret));
        chk("rnd err_index", 64'(err_index), 64'(m_eidx));
        chk("rnd err_pc", 64'(err_pc), 64'(m_epc));
        chk("rnd err_wnum", 64'(err_wnum), 64'(m_ewnum));
        chk("rnd err_wdata", 64'(err_wdata), 64'(m_ewdata));
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
        m_check();
    endtask

    task automatic rnd_reset();
        idle_inputs();
        resetn = 0;
        m_reset();
        #1;
        m_check();
        @(posedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic noise();
        idle_inputs();
        debug_wb_rf_wdata = $urandom;
        debug_wb_rf_wnum  = 5'($urandom_range(0, 31));
        debug_wb_pc       = 32'h1c001000 | 32'($urandom_range(0, 4095));
        case ($urandom_range(0, 2))
            0: ;
            1: begin debug_wb_rf_we = 4'($urandom_range(1, 15)); debug_wb_rf_wnum = 0; end
            default: debug_wb_pc = END_PC;  // END_PC without a write is not an end
        endcase
        if ($urandom_range(0, 3) == 0) begin
            load_en = 1; load_addr = AW'($urandom_range(0, 15));
            load_data = {$urandom, $urandom, 5'($urandom)};
        end
        if ($urandom_range(0, 7) == 0) start = 1;
    endtask

    logic [68:0] ent [16];

    initial begin
        #5ms;
        $display("FAIL sim_guard: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        load_addr = 0; load_data = 0; trace_len = 3;
        resetn = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            load_en = 1; load_addr = AW'(i);
            load_data = {PC0 + 32'(4 * i), 5'(i + 1), 32'(i + 1)};
            @(negedge clk);
        end
        load_en = 0;

        // full matching trace, then a start in PASS is ignored
        tbl.push_back(s_row(3));
        tbl.push_back(ok_row(PC0, 1, 1));
        tbl.push_back(ok_row(PC1, 2, 2));
        tbl.push_back(ok_row(PC2, 3, 3));
        tbl.push_back(mk(0, 0, 3, END_PC, 4'hf, 0, 0, 0, 1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0));
        // wrong wdata on second write, later writes do not overwrite capture
        tbl.push_back(r_row());
        tbl.push_back(s_row(3));
        tbl.push_back(ok_row(PC0, 1, 1));
        tbl.push_back(mk(0, 0, 3, PC1, 4'hf, 2, 5, 0, 0, 1, 1, 1, PC1, 5));
        tbl.push_back(mk(0, 0, 3, PC2, 4'hf, 3, 3, 0, 0, 1, 1, 1, PC1, 5));
        // r0 writes and we=0 cycles interleaved
        tbl.push_back(r_row());
        tbl.push_back(s_row(3));
        tbl.push_back(mk(0, 0, 3, 32'h1c000050, 4'hf, 0, 9, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(ok_row(PC0, 1, 1));
        tbl.push_back(mk(0, 0, 3, 32'h1c0000a0, 4'h0, 3, 77, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 32'h1c000060, 4'h1, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(ok_row(PC1, 2, 2));
        tbl.push_back(mk(0, 0, 3, END_PC, 4'h0, 2, 2, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(ok_row(PC2, 3, 3));
        tbl.push_back(mk(0, 0, 3, END_PC, 4'hf, 0, 0, 0, 1, 0, 3, 0, 0, 0));
        // END_PC after two of three writes
        tbl.push_back(r_row());
        tbl.push_back(s_row(3));
        tbl.push_back(ok_row(PC0, 1, 1));
        tbl.push_back(ok_row(PC1, 2, 2));
        tbl.push_back(mk(0, 0, 3, END_PC, 4'h2, 0, 32'h1234, 0, 0, 1, 2, 2, END_PC, 32'h1234));
        // extra write beyond trace_len
        tbl.push_back(r_row());
        tbl.push_back(s_row(3));
        tbl.push_back(ok_row(PC0, 1, 1));
        tbl.push_back(ok_row(PC1, 2, 2));
        tbl.push_back(ok_row(PC2, 3, 3));
        tbl.push_back(mk(0, 0, 3, 32'h1c00000c, 4'hf, 4, 4, 0, 0, 1, 3, 3, 32'h1c00000c, 4));
        // reset mid-RUN, then rerun without reloading
        tbl.push_back(r_row());
        tbl.push_back(s_row(3));
        tbl.push_back(ok_row(PC0, 1, 1));
        tbl.push_back(r_row());
        tbl.push_back(s_row(3));
        tbl.push_back(ok_row(PC0, 1, 1));
        tbl.push_back(ok_row(PC1, 2, 2));
        tbl.push_back(ok_row(PC2, 3, 3));
        tbl.push_back(mk(0, 0, 3, END_PC, 4'hf, 0, 0, 0, 1, 0, 3, 0, 0, 0));
        // trace_len == 0
        tbl.push_back(r_row());
        tbl.push_back(s_row(0));
        tbl.push_back(mk(0, 0, 0, PC0, 4'hf, 1, 1, 0, 0, 1, 0, 0, PC0, 1));
        tbl.push_back(r_row());
        tbl.push_back(s_row(0));
        tbl.push_back(mk(0, 0, 0, END_PC, 4'h8, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            idle_inputs();
            if (v.rst) begin
                resetn = 0;
                #1;
                check_row(i, v);
                @(posedge clk);
                @(negedge clk);
                resetn = 1;
            end else begin
                trace_len = v.len; start = v.st; debug_wb_pc = v.pc;
                debug_wb_rf_we = v.we; debug_wb_rf_wnum = v.wnum; debug_wb_rf_wdata = v.wdata;
                @(posedge clk);
                @(negedge clk);
                check_row(i, v);
            end
        end

        // watchdog: no writes after start, timeout on the 21st edge
        idle_inputs();
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        trace_len = 3; start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("wdog edge%0d timeout", k), 64'(timeout), 64'd0);
        end
        @(negedge clk);
        chk("wdog edge21 timeout", 64'(timeout), 64'd1);
        chk("wdog edge21 busy", 64'(busy), 64'd0);
        chk("wdog edge21 done", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
        chk("wdog hold timeout", 64'(timeout), 64'd1);
        chk("wdog hold busy", 64'(busy), 64'd0);

        // randomized traces against the reference model
        for (int t = 0; t < 40; t++) begin
            int len;
            bit last_end;
            rnd_reset();
            len      = $urandom_range(0, 16);
            last_end = (len > 0) && ($urandom_range(0, 2) == 0);
            for (int i = 0; i < len; i++) begin
                ent[i] = {32'h1c001000 | 32'($urandom_range(0, 4095)),
                          5'($urandom_range(1, 31)), 32'($urandom)};
                if (last_end && i == len - 1) ent[i][68:37] = END_PC;
                idle_inputs();
                load_en = 1; load_addr = AW'(i); load_data = ent[i];
                cyc();
            end
            idle_inputs();
            trace_len = LW'(len); start = 1;
            cyc();
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    noise();
                    cyc();
                end
                idle_inputs();
                if ($urandom_range(0, 39) != 0) begin
                    debug_wb_pc       = ent[i][68:37];
                    debug_wb_rf_wnum  = ent[i][36:32];
                    debug_wb_rf_wdata = ent[i][31:0] ^ 32'($urandom_range(0, 29) == 0);
                    debug_wb_rf_we    = 4'($urandom_range(1, 15));
                end
                cyc();
            end
            idle_inputs();
            case ($urandom_range(0, 3))
                0: begin
                    debug_wb_pc = END_PC; debug_wb_rf_we = 4'hf; cyc();
                end
                1: begin
                    debug_wb_pc = 32'h1c001000 | 32'($urandom_range(0, 4095));
                    debug_wb_rf_we = 4'h1; debug_wb_rf_wnum = 5'($urandom_range(1, 31));
                    debug_wb_rf_wdata = $urandom;
                    cyc();
                    idle_inputs();
                    debug_wb_pc = END_PC; debug_wb_rf_we = 4'hf; cyc();
                end
                2: ;
                default: begin
                    debug_wb_pc = END_PC; debug_wb_rf_we = 4'h4; cyc(); cyc();
                end
            endcase
            idle_inputs();
            repeat (25) cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
